// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup in IF,
// training and mispredict/redirect resolution in EX, plus branch/miss statistics.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - 2 - IDX_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      PCF,
    output logic             PredTakenF,
    output logic [31:0]      PredTargetF,
    input  logic [31:0]      PCE,
    input  logic             IsBranchE,
    input  logic             BranchE,
    input  logic [31:0]      BranchTargetE,
    input  logic             PredTakenE,
    input  logic [31:0]      PredTargetE,
    input  logic             StallE,
    input  logic             ClrCnt,
    output logic             MispredictE,
    output logic [31:0]      RedirectPCE,
    output logic [CNT_W-1:0] BrCnt,
    output logic [CNT_W-1:0] MissCnt
);
    localparam int ENTRIES = 1 << IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e, train;
    logic [31:0]      pc_plus4_e;

    assign idx_f = PCF[IDX_W+1:2];
    assign tag_f = PCF[31:IDX_W+2];
    assign idx_e = PCE[IDX_W+1:2];
    assign tag_e = PCE[31:IDX_W+2];

    // Lookup reads the registered table only, so a same-cycle write is not visible.
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredTakenF  = hit_f && ctr_q[idx_f][1];
    assign PredTargetF = PredTakenF ? target_q[idx_f] : 32'd0;

    assign hit_e      = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign pc_plus4_e = PCE + 32'd4;
    assign train      = IsBranchE && !StallE;

    assign MispredictE = IsBranchE &&
                         ((BranchE != PredTakenE) ||
                          (BranchE && PredTakenE && (PredTargetE != BranchTargetE)));
    assign RedirectPCE = (IsBranchE && BranchE) ? BranchTargetE : pc_plus4_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (train) begin
            if (hit_e) begin
                if (BranchE) begin
                    if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
                    target_q[idx_e] <= BranchTargetE;
                end else if (ctr_q[idx_e] != 2'b00) begin
                    ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
                end
            end else if (BranchE) begin
                // Miss on a taken branch allocates; a not-taken miss never evicts.
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= BranchTargetE;
                ctr_q[idx_e]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BrCnt   <= '0;
            MissCnt <= '0;
        end else if (ClrCnt) begin
            BrCnt   <= '0;
            MissCnt <= '0;
        end else if (train) begin
            BrCnt   <= BrCnt + CNT_W'(1);
            MissCnt <= MissCnt + CNT_W'(MispredictE);
        end
    end

endmodule
